sm_mult_seq: RTL
================

// Module: sm_mult_seq
// PURPOSE
// - Parametrised sequential sign-magnitude multiplier for the FFT butterfly datapath.
// - Operands are sign bit at MSB plus MAG_W-bit magnitude. Magnitude is formed by an
//   iterative shift-add engine; the product sign is XOR of the operand signs.
// - Valid/ready handshakes on both sides let FFT stages stall it.
// - Optional early termination shortens latency for small multipliers.
// PARAMETERS
// - MAG_W       8  magnitude width of each operand (sign adds 1 bit); legal values >= 2
// - EARLY_EXIT  0  1: finish as soon as the remaining multiplier bits are all zero
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - in_valid   in   1          a/b valid
// - in_ready   out  1          engine idle; operands accepted when in_valid & in_ready
// - a          in   MAG_W+1    multiplicand: [MAG_W]=sign, [MAG_W-1:0]=magnitude
// - b          in   MAG_W+1    multiplier, same format
// - out_valid  out  1          prdct holds a finished result
// - out_ready  in   1          consumer takes prdct when out_valid & out_ready
// - prdct      out  2*MAG_W+1  [2*MAG_W]=sign, [2*MAG_W-1:0]=magnitude
// BEHAVIOUR
// - One clock domain. Reset is asynchronous and active-low.
// - Reset values:
//   - state = IDLE, so in_ready = 1.
//   - out_valid = 0, prdct = 0.
//   - Accumulator, counter and operand registers = 0.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - in_ready  = (state == IDLE).
//   - out_valid = (state == DONE).
// - IDLE: on the edge where in_valid & in_ready (edge k), the block
//   - latches mcand = a[MAG_W-1:0] and msr = b[MAG_W-1:0];
//   - latches sgn = a[MAG_W] ^ b[MAG_W];
//   - clears acc (2*MAG_W bits) and cnt;
//   - moves to BUSY.
// - BUSY, one iteration per edge:
//   - if msr[0], acc += mcand << cnt;
//   - msr >>= 1; cnt++.
//   - Go to DONE on the edge where cnt == MAG_W-1, or, if EARLY_EXIT = 1, where the
//     shifted msr becomes 0.
//   - Latency: fixed MAG_W edges from edge k when EARLY_EXIT = 0. With EARLY_EXIT = 1,
//     max(1, msb index of |b| + 1) edges.
// - DONE entry: prdct = {sgn & (acc != 0), acc}. Negative zero is never emitted; a
//   zero magnitude always carries sign 0.
// - DONE: prdct and out_valid are held stable until out_ready = 1.
//   - On the edge with out_ready = 1, the block returns to IDLE and out_valid drops.
//   - in_ready rises in the following cycle; there is no same-cycle drain+accept.
// - Arithmetic: the magnitude product always fits in 2*MAG_W bits; there is no overflow
//   and no saturation.
// - in_valid while busy or done is ignored, and a/b may change freely then. The
//   producer must hold a/b until it sees in_ready.
// - out_ready while out_valid = 0 has no effect.
// - Reset asserted mid-operation: the in-flight operation is discarded. All state
//   returns to the reset values immediately (asynchronously), with no spurious out_valid.
// TESTING (MAG_W = 8 unless noted)
// - a = 9'h105 (-5), b = 9'h003 (+3), out_ready = 1
//   -> prdct = 17'h1000F; out_valid exactly 8 edges after accept, high for 1 cycle.
// - a = 9'h0FF, b = 9'h1FF
//   -> prdct = 17'h1FE01 (-65025); then a = 9'h1FF, b = 9'h1FF -> 17'h0FE01.
// - a = 9'h100 (-0), b = 9'h107 -> prdct = 17'h00000 (sign cleared);
//   a = 9'h1AA, b = 9'h000 -> 17'h00000.
// - Backpressure: hold out_ready = 0 for 5 cycles after out_valid
//   -> prdct, out_valid stable, in_ready = 0, new in_valid ignored;
//   out_ready = 1 -> IDLE, in_ready = 1 next cycle.
// - Pull rst_n low after the 3rd BUSY edge
//   -> out_valid = 0, prdct = 0, in_ready = 1 immediately;
//   a fresh operation after release is correct.
// - EARLY_EXIT = 1: a = 9'h0AA, b = 9'h001 -> 17'h000AA 1 edge after accept;
//   b = 9'h005 -> 17'h00352 after 3 edges; b = 9'h080 -> 8 edges.

Source files
------------

// File: rtl/sm_mult_seq.sv
// sm_mult_seq: sequential sign-magnitude multiplier with valid/ready handshakes.
// The magnitude is built by a shift-add engine, one multiplier bit per clock.
// The product sign is the XOR of the operand signs, forced to 0 for a zero result.
module sm_mult_seq #(
    parameter int MAG_W      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W:0]   a,
    input  logic [MAG_W:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*MAG_W:0] prdct
);

    localparam int CNT_W = $clog2(MAG_W);
    localparam int ACC_W = 2 * MAG_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    logic [MAG_W-1:0] mcand_q;
    logic [MAG_W-1:0] msr_q;
    logic             sgn_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W:0]   prdct_q;

    logic [ACC_W-1:0] partial;
    logic [ACC_W-1:0] acc_d;
    logic [MAG_W-1:0] msr_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_iter;

    // One shift-add iteration and the decision whether it is the final one
    always_comb begin
        partial   = {{MAG_W{1'b0}}, mcand_q} << cnt_q;
        acc_d     = msr_q[0] ? (acc_q + partial) : acc_q;
        msr_d     = msr_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        last_iter = (cnt_q == CNT_LAST) || (EARLY_EXIT && (msr_d == '0));
    end

    // Control FSM plus datapath registers; the product is captured on DONE entry
    // from the final iteration's accumulator value so no extra cycle is spent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            msr_q   <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prdct_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= a[MAG_W-1:0];
                        msr_q   <= b[MAG_W-1:0];
                        sgn_q   <= a[MAG_W] ^ b[MAG_W];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    msr_q <= msr_d;
                    cnt_q <= cnt_d;
                    if (last_iter) begin
                        prdct_q <= {sgn_q & (acc_d != '0), acc_d};
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are decoded straight from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        prdct     = prdct_q;
    end

endmodule
